// File: rtl/frame_request_gen.sv
// frame_request_gen: frame request source for the CMOS capture / DDR3 write
// path. SD mode issues periodic requests from a loadable period timer; USB
// mode issues one request per host pulse. A request is a level held until
// frame_ack. Triggers that land while a request is pending bump miss_cnt.
//
// Optional build macro FRAME_REQ_TIMEOUT_EN: abandon a request after
// ACK_TIMEOUT cycles without an ack (pulses ack_timeout, counts a miss).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   initial_done        low = synchronous hold/clear (period, miss_cnt kept)
//   usb_request         pulse: select USB mode and trigger one request
//   sd_request          pulse: select SD periodic mode
//   period_cfg/_load    new period (clamped to >= 2) and its load strobe
//   frame_ack           capture path accepted the current request
//   request_new_frame   request level
//   frame_tick          one-cycle pulse per trigger (accepted or missed)
//   usb_mode            1 = USB on-demand, 0 = SD periodic
//   miss_cnt            saturating count of lost triggers
//   ack_timeout         one-cycle pulse when a request is abandoned
module frame_request_gen #(
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 2000000,
  parameter int MISS_W         = 8,
  parameter int ACK_TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                initial_done,
  input  logic                usb_request,
  input  logic                sd_request,
  input  logic [PERIOD_W-1:0] period_cfg,
  input  logic                period_load,
  input  logic                frame_ack,
  output logic                request_new_frame,
  output logic                frame_tick,
  output logic                usb_mode,
  output logic [MISS_W-1:0]   miss_cnt,
  output logic                ack_timeout
);

  typedef enum logic {IDLE, REQ} state_t;

  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, cnt_q, cnt_d, cfg_eff;
  logic                usb_q, usb_d, tick_q, tick_d, ato_q, ato_d;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                running, wrap, trig, to_hit;

  assign cfg_eff  = (period_cfg < PERIOD_W'(2)) ? PERIOD_W'(2) : period_cfg;
  assign running  = initial_done && !usb_q;
  assign wrap     = running && (cnt_q == period_q - PERIOD_W'(1));
  // A load on the wrap cycle restarts the count and eats that trigger.
  assign trig     = initial_done && (usb_request || (wrap && !period_load));
  assign miss_inc = (&miss_q) ? miss_q : miss_q + MISS_W'(1);

  // Counter sits at 0 whenever it is not free-running in SD mode; covers
  // entering SD mode (usb_q still set on the sd_request cycle).
  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if (!initial_done || period_load || usb_q || usb_request || wrap)
      cnt_d = '0;
  end

  always_comb begin
    usb_d = usb_q;
    if (!initial_done)    usb_d = 1'b0;
    else if (usb_request) usb_d = 1'b1;
    else if (sd_request)  usb_d = 1'b0;
  end

`ifdef FRAME_REQ_TIMEOUT_EN
  localparam int TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  assign to_hit = (tcnt_q >= TO_W'(ACK_TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    ato_d   = 1'b0;
    miss_d  = miss_q;
`ifdef FRAME_REQ_TIMEOUT_EN
    // Holds once the limit is reached so a trigger on that cycle only defers it.
    tcnt_d  = (state_q == REQ && !to_hit) ? tcnt_q + TO_W'(1) : tcnt_q;
`endif
    if (!initial_done) begin
      state_d = IDLE;
`ifdef FRAME_REQ_TIMEOUT_EN
      tcnt_d  = '0;
`endif
    end else begin
      tick_d = trig;
      case (state_q)
        IDLE: begin
          if (trig) state_d = REQ;
`ifdef FRAME_REQ_TIMEOUT_EN
          tcnt_d = '0;
`endif
        end
        REQ: begin
          if (frame_ack) begin
            state_d = trig ? REQ : IDLE;
`ifdef FRAME_REQ_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else if (trig) begin
            miss_d = miss_inc;
          end else if (to_hit) begin
            state_d = IDLE;
            ato_d   = 1'b1;
            miss_d  = miss_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= PERIOD_W'(DEFAULT_PERIOD);
      cnt_q    <= '0;
      usb_q    <= 1'b0;
      tick_q   <= 1'b0;
      ato_q    <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      usb_q   <= usb_d;
      tick_q  <= tick_d;
      ato_q   <= ato_d;
      miss_q  <= miss_d;
      if (period_load) period_q <= cfg_eff;
    end
  end

`ifdef FRAME_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end
`endif

  assign request_new_frame = (state_q == REQ);
  assign frame_tick        = tick_q;
  assign usb_mode          = usb_q;
  assign miss_cnt          = miss_q;
`ifdef FRAME_REQ_TIMEOUT_EN
  assign ack_timeout       = ato_q;
`else
  assign ack_timeout       = 1'b0;
  logic unused_ato;
  assign unused_ato        = ato_q ^ to_hit;
`endif

endmodule

// File: tb/tb_frame_request_gen.sv
// Bench for frame_request_gen. The reference model schedules SD triggers as
// absolute edge deadlines (restart edge + period) and tracks the request as
// a pending flag with the edge it was armed on.
module tb_frame_request_gen;
  localparam int PW = 24, DP = 12, MW = 2, AT = 20;

  logic          clk = 1'b0, rst_n = 1'b0, initial_done = 1'b0;
  logic          usb_request = 1'b0, sd_request = 1'b0, period_load = 1'b0;
  logic          frame_ack = 1'b0;
  logic [PW-1:0] period_cfg = '0;
  logic          request_new_frame, frame_tick, usb_mode, ack_timeout;
  logic [MW-1:0] miss_cnt;

  frame_request_gen #(.PERIOD_W(PW), .DEFAULT_PERIOD(DP), .MISS_W(MW),
                      .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .initial_done(initial_done),
    .usb_request(usb_request), .sd_request(sd_request),
    .period_cfg(period_cfg), .period_load(period_load),
    .frame_ack(frame_ack), .request_new_frame(request_new_frame),
    .frame_tick(frame_tick), .usb_mode(usb_mode), .miss_cnt(miss_cnt),
    .ack_timeout(ack_timeout));

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;

  // reference model
  int edge_n = 0, m_p, m_dl, m_rose, m_miss;
  bit m_usb, m_pend, m_tick, m_ato;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  task automatic check_all();
    check("request_new_frame", 32'(request_new_frame), 32'(m_pend));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("usb_mode", 32'(usb_mode), 32'(m_usb));
    check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    check("ack_timeout", 32'(ack_timeout), 32'(m_ato));
  endtask

  task automatic model_reset();
    m_p = DP; m_usb = 0; m_pend = 0; m_tick = 0; m_ato = 0; m_miss = 0;
    m_rose = 0; m_dl = edge_n + m_p;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << MW) - 1) ? v : v + 1;
  endfunction

  task automatic model_edge();
    bit running, at_dl, trg, restart;
    edge_n++;
    running = initial_done && !m_usb;
    at_dl   = (edge_n == m_dl);
    trg     = initial_done && (usb_request || (running && at_dl && !period_load));
    restart = !initial_done || period_load || m_usb || usb_request || (running && at_dl);
    if (period_load) m_p = (int'(period_cfg) < 2) ? 2 : int'(period_cfg);
    if (restart) m_dl = edge_n + m_p;
    m_ato = 0;
    if (!initial_done) begin
      m_pend = 0; m_tick = 0; m_usb = 0;
    end else begin
      m_tick = trg;
      if (m_pend) begin
        if (frame_ack) begin
          m_pend = trg;
          if (trg) m_rose = edge_n;
        end else if (trg) m_miss = sat_inc(m_miss);
`ifdef FRAME_REQ_TIMEOUT_EN
        else if (edge_n >= m_rose + AT) begin
          m_pend = 0; m_ato = 1; m_miss = sat_inc(m_miss);
        end
`endif
      end else if (trg) begin
        m_pend = 1; m_rose = edge_n;
      end
      if (usb_request) m_usb = 1;
      else if (sd_request) m_usb = 0;
    end
  endtask

  task automatic cyc(input bit ur, input bit sr, input bit pl, input int cfg,
                     input bit ak, input bit idn);
    usb_request = ur; sd_request = sr; period_load = pl;
    period_cfg = PW'(cfg); frame_ack = ak; initial_done = idn;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle_cycles(input int n, input bit ak);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ak, 1);
  endtask

  // ack exactly 3 cycles after each request rises
  task automatic ack3_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, m_pend && (edge_n - m_rose == 3), 1);
  endtask

  task automatic drain();
    int k = 0;
    while (m_pend && k < 10) begin cyc(0, 0, 0, 0, 1, 1); k++; end
    check("drain_bound", 32'(m_pend), 32'(0));
  endtask

  initial begin
    model_reset();
    #2 check_all();                        // reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();

    // hold, then default period with no ack
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    idle_cycles(30, 0);

    // load P=10, ack 3 cycles after each request
    drain();
    cyc(0, 0, 1, 10, 0, 1);
    ack3_cycles(60);

    // never ack: misses saturate at all-ones
    idle_cycles(60, 0);
    check("miss_saturated", 32'(miss_cnt), 32'(3));

    // usb and sd together: usb wins, counter frozen
    drain();
    cyc(1, 1, 0, 0, 0, 1);
    check("usb_wins", 32'(usb_mode), 32'(1));
    idle_cycles(3, 0);
    drain();
    idle_cycles(15, 0);
    cyc(1, 0, 0, 0, 0, 1);
    drain();
    cyc(0, 1, 0, 0, 0, 1);
    ack3_cycles(25);

    // period_cfg=0 clamps to 2; ack every cycle re-arms on each trigger
    cyc(0, 0, 1, 0, 0, 1);
    idle_cycles(12, 1);

    // initial_done low keeps period and miss count
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    idle_cycles(6, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit ur, sr, pl, ak, idn;
      ur  = ($urandom_range(99) < 3);
      sr  = ($urandom_range(99) < 3);
      pl  = ($urandom_range(99) < 2);
      ak  = ($urandom_range(99) < 30);
      idn = ($urandom_range(99) < 98);
      cyc(ur, sr, pl, int'($urandom_range(15)), ak, idn);
    end

    // long period, no ack: held (or abandoned after AT with the timeout build)
    cyc(0, 1, 1, 100, 0, 1);
    drain();
    begin
      int k = 0;
      while (!m_pend && k < 150) begin cyc(0, 0, 0, 0, 0, 1); k++; end
      check("wait_request", 32'(m_pend), 32'(1));
    end
    idle_cycles(30, 0);

    // reset mid-request: request drops with no clock edge
    cyc(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_req", 32'(request_new_frame), 32'(0));
    model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    idle_cycles(15, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
